// File: rtl/ps2_key_activation_decoder_pkg.sv
// Shared PS/2 scan-code constants, decoder mode encodings and FSM state type.
package ps2_codes_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int MODE_LEVEL  = 0;
   localparam int MODE_PULSE  = 1;
   localparam int MODE_TOGGLE = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_t;

   // Lowest-index priority encoder; 4'hF when nothing is set.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] r;
      r = 4'hF;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            r = i[3:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_activation_decoder_if.sv
// Byte-strobed scan-code input and activation outputs of the key decoder.
interface ps2_key_activation_decoder_if #(
   parameter int N_CH = 3
);
   logic            code_valid;
   logic [7:0]      code;
   logic [N_CH-1:0] activation;
   logic [3:0]      active_idx;
   logic            key_held;
   logic            prefix_err;

   modport master (
      output code_valid, code,
      input  activation, active_idx, key_held, prefix_err
   );

   modport slave (
      input  code_valid, code,
      output activation, active_idx, key_held, prefix_err
   );
endinterface

// File: rtl/ps2_key_activation_decoder_prefix_timer.sv
// Idle-cycle counter for a pending prefix; expired_o is high while the count sits at TIMEOUT.
module ps2_prefix_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int            CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Saturating count, so the limit is held rather than wrapped.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CW{1'b0}};
      end else if (enable_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/ps2_key_activation_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and maps make/break codes onto
// one-hot activation channels in level, pulse or toggle mode.
module ps2_key_activation_decoder
   import ps2_codes_pkg::*;
#(
   parameter int              N_CH      = 3,
   parameter logic [N_CH*8-1:0] KEY_CODES = {8'h7D, 8'h75, 8'h6C},
   parameter logic [N_CH-1:0] EXT_MASK  = {N_CH{1'b0}},
   parameter int              MODE      = MODE_LEVEL,
   parameter int              TIMEOUT   = 1023
) (
   input logic                         clk,
   input logic                         reset,
   ps2_key_activation_decoder_if.slave bus
);
   ps2_state_t      state_q, state_d, state_eff_s;
   logic [N_CH-1:0] act_q, act_d;
   logic [3:0]      idx_q, idx_d;
   logic            held_q, held_d;
   logic            err_q, err_d;

   logic            expired_s;
   logic            dec_make_s, dec_break_s, err_f0_s, ext_s;
   logic [N_CH-1:0] match_s;
   logic [3:0]      hit_idx_s;
   logic            hit_s;
   logic [N_CH-1:0] hit_oh_s;

   ps2_prefix_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (bus.code_valid || (state_q == IDLE)),
      .enable_i  (state_q != IDLE),
      .expired_o (expired_s)
   );

   // A timeout drops the prefix first, so a byte in that cycle is decoded from IDLE.
   assign state_eff_s = expired_s ? IDLE : state_q;
   assign ext_s       = (state_eff_s == EXT) || (state_eff_s == EXT_BRK);

   for (genvar g = 0; g < N_CH; g++) begin : g_match
      assign match_s[g] = (bus.code == KEY_CODES[8*g +: 8]) && (ext_s == EXT_MASK[g]);
   end

   assign hit_s     = |match_s;
   assign hit_idx_s = lowest_set(16'(match_s));
   assign hit_oh_s  = N_CH'(1) << hit_idx_s;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         act_q   <= {N_CH{1'b0}};
         idx_q   <= 4'hF;
         held_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         idx_q   <= idx_d;
         held_q  <= held_d;
         err_q   <= err_d;
      end
   end

   // Prefix tracking; E0 after F0 is folded into the extended-break state.
   always_comb begin
      state_d     = state_eff_s;
      dec_make_s  = 1'b0;
      dec_break_s = 1'b0;
      err_f0_s    = 1'b0;
      if (bus.code_valid) begin
         case (state_eff_s)
            IDLE: begin
               if (bus.code == PS2_EXT) begin
                  state_d = EXT;
               end else if (bus.code == PS2_BRK) begin
                  state_d = BRK;
               end else begin
                  dec_make_s = 1'b1;
               end
            end
            EXT: begin
               if (bus.code == PS2_BRK) begin
                  state_d = EXT_BRK;
               end else if (bus.code == PS2_EXT) begin
                  state_d = EXT;
               end else begin
                  dec_make_s = 1'b1;
                  state_d    = IDLE;
               end
            end
            BRK: begin
               if (bus.code == PS2_BRK) begin
                  err_f0_s = 1'b1;
               end else if (bus.code == PS2_EXT) begin
                  state_d = EXT_BRK;
               end else begin
                  dec_break_s = 1'b1;
                  state_d     = IDLE;
               end
            end
            EXT_BRK: begin
               if (bus.code == PS2_BRK) begin
                  err_f0_s = 1'b1;
               end else if (bus.code == PS2_EXT) begin
                  state_d = EXT_BRK;
               end else begin
                  dec_break_s = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_eff_s;
      end
   end

   // Channel outputs; pulse mode drops activation back to zero every cycle.
   always_comb begin
      act_d  = (MODE == MODE_PULSE) ? {N_CH{1'b0}} : act_q;
      idx_d  = idx_q;
      held_d = held_q;
      err_d  = expired_s || err_f0_s;
      if (dec_make_s && hit_s) begin
         idx_d  = hit_idx_s;
         held_d = 1'b1;
         case (MODE)
            MODE_LEVEL: begin
               act_d = hit_oh_s;
            end
            MODE_PULSE: begin
               // Typematic repeats of the held key do not re-pulse.
               if (!(held_q && (idx_q == hit_idx_s))) begin
                  act_d = hit_oh_s;
               end else begin
                  act_d = {N_CH{1'b0}};
               end
            end
            MODE_TOGGLE: begin
               act_d = (act_q ^ hit_oh_s) & hit_oh_s;
            end
            default: begin
               act_d = hit_oh_s;
            end
         endcase
      end else if (dec_make_s && (MODE == MODE_LEVEL)) begin
         act_d = {N_CH{1'b0}};
         idx_d = 4'hF;
      end else if (dec_break_s && hit_s && (hit_idx_s == idx_q)) begin
         held_d = 1'b0;
         if (MODE == MODE_LEVEL) begin
            act_d = {N_CH{1'b0}};
         end else begin
            act_d = (MODE == MODE_PULSE) ? {N_CH{1'b0}} : act_q;
         end
      end else begin
         idx_d = idx_q;
      end
   end

   assign bus.activation = act_q;
   assign bus.active_idx = idx_q;
   assign bus.key_held   = held_q;
   assign bus.prefix_err = err_q;

endmodule
